dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the single-port `data_mem` (combinational read, write on `clk` edge). It shares the memory between port 0 (core load/store unit) and port 1 (DMA/debug master). It grants one access per cycle and registers read data back to the winning requester. It also supports a lock for atomic read-modify-write sequences. It sits between the requesters and `data_mem` and drives that memory's `addr`/`wd`/`we` and consumes its `rd`.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_pick.sv | 38 +++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  localparam logic ARB_P0 = 1'b0;
  localparam logic ARB_P1 = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection; DMEM_ARB_RR_EN selects round-robin instead of port-0 priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  arb_state_t state,
`ifdef DMEM_ARB_RR_EN
  input  logic       last_gnt,
`endif
  output logic       gnt0,
  output logic       gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state)
      ARB_LOCK0: gnt0 = req0;
      ARB_LOCK1: gnt1 = req1;
      default: begin
        if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
          // On conflict the port that did not win last time goes first.
          gnt0 = (last_gnt != ARB_P0);
          gnt1 = (last_gnt == ARB_P0);
`else
          gnt0 = 1'b1;
`endif
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory with lock support.
// Build option: DMEM_ARB_RR_EN enables round-robin conflict resolution.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wd,
  input  logic          p0_lock,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wd,
  input  logic          p1_lock,
  output logic          p0_gnt,
  output logic          p1_gnt,
  output logic          p0_rvalid,
  output logic          p1_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output arb_state_t    dbg_state
);

  // Handshake: a requester holds req (and its addr/wd/we/lock) until it sees gnt;
  // the access takes place at the rising edge where req && gnt.

  arb_state_t    state_q, state_d;
  logic          pick_gnt0, pick_gnt1;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

`ifdef DMEM_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;
`endif

  dmem_arb_pick u_pick (
    .req0     (p0_req),
    .req1     (p1_req),
    .state    (state_q),
`ifdef DMEM_ARB_RR_EN
    .last_gnt (last_gnt_q),
`endif
    .gnt0     (pick_gnt0),
    .gnt1     (pick_gnt1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (p0_gnt && p0_lock) begin
          state_d = ARB_LOCK0;
        end else if (p1_gnt && p1_lock) begin
          state_d = ARB_LOCK1;
        end
      end
      ARB_LOCK0: if (!p0_lock) state_d = ARB_IDLE;
      ARB_LOCK1: if (!p1_lock) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Grants are forced low during reset so nothing reaches the memory.
  always_comb begin
    p0_gnt   = pick_gnt0 & rst_n;
    p1_gnt   = pick_gnt1 & rst_n;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (p0_gnt) begin
      mem_we   = p0_we;
      mem_addr = p0_addr;
      mem_wd   = p0_wd;
    end else if (p1_gnt) begin
      mem_we   = p1_we;
      mem_addr = p1_addr;
      mem_wd   = p1_wd;
    end
  end

  always_comb begin
    rvalid0_d = p0_gnt & ~p0_we;
    rvalid1_d = p1_gnt & ~p1_we;
    rdata0_d  = rvalid0_d ? mem_rd : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rd : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (p0_gnt) begin
      last_gnt_d = ARB_P0;
    end else if (p1_gnt) begin
      last_gnt_d = ARB_P1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= ARB_P1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  assign p0_rvalid = rvalid0_q;
  assign p1_rvalid = rvalid1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps plus random traffic checked against a behavioural model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req [2];
  logic          we  [2];
  logic          lock[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wd  [2];
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_wd, mem_rd;
  logic [AW-1:0] mem_addr;
  arb_state_t    dbg_state;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wd(wd[0]), .p0_lock(lock[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wd(wd[1]), .p1_lock(lock[1]),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .dbg_state(dbg_state)
  );

  // Environment: the single-port data_mem (combinational read, write on the edge).
  logic [DW-1:0] mem [NW] = '{default: '0};
  assign mem_rd = mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wd;

  // Reference model: lock owner as a port number (-1 = none), expected memory and responses.
  int            owner;
  int            cur_w;
  logic [DW-1:0] ref_mem[NW];
  logic [DW-1:0] exp_rdata[2];
  logic          exp_rvalid[2];
`ifdef DMEM_ARB_RR_EN
  int            last_win;
`endif
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pred_winner();
    if (owner >= 0) return req[owner] ? owner : -1;
    if (req[0] && req[1]) begin
`ifdef DMEM_ARB_RR_EN
      return (last_win == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  function automatic arb_state_t pred_state();
    if (owner == 0) return ARB_LOCK0;
    if (owner == 1) return ARB_LOCK1;
    return ARB_IDLE;
  endfunction

  task automatic model_reset();
    owner = -1;
`ifdef DMEM_ARB_RR_EN
    last_win = 1;
`endif
    for (int p = 0; p < 2; p++) begin
      exp_rdata[p]  = '0;
      exp_rvalid[p] = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; lock[p] = 1'b0; addr[p] = '0; wd[p] = '0;
    end
  endtask

  // Entered 1 time unit after a rising edge; checks at the falling edge, then models the next edge.
  task automatic cycle();
    int w;
    #4;
    w = pred_winner();
    cur_w = w;
    check("p0_gnt", 64'(p0_gnt), 64'(w == 0));
    check("p1_gnt", 64'(p1_gnt), 64'(w == 1));
    check("mem_we", 64'(mem_we), (w >= 0) ? 64'(we[w]) : 64'd0);
    check("mem_addr", 64'(mem_addr), (w >= 0) ? 64'(addr[w]) : 64'd0);
    check("mem_wd", 64'(mem_wd), (w >= 0) ? 64'(wd[w]) : 64'd0);
    check("p0_rvalid", 64'(p0_rvalid), 64'(exp_rvalid[0]));
    check("p1_rvalid", 64'(p1_rvalid), 64'(exp_rvalid[1]));
    check("p0_rdata", 64'(p0_rdata), 64'(exp_rdata[0]));
    check("p1_rdata", 64'(p1_rdata), 64'(exp_rdata[1]));
    check("state", 64'(dbg_state), 64'(pred_state()));
    @(posedge clk);
    exp_rvalid[0] = 1'b0;
    exp_rvalid[1] = 1'b0;
    if (w >= 0) begin
      if (we[w]) begin
        ref_mem[addr[w][3:0]] = wd[w];
      end else begin
        exp_rdata[w]  = ref_mem[addr[w][3:0]];
        exp_rvalid[w] = 1'b1;
      end
`ifdef DMEM_ARB_RR_EN
      last_win = w;
`endif
    end
    if (owner >= 0) begin
      if (!lock[owner]) owner = -1;
    end else if (w >= 0 && lock[w]) begin
      owner = w;
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p0_gnt"}, 64'(p0_gnt), 64'd0);
    check({tag, "_p1_gnt"}, 64'(p1_gnt), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wd"}, 64'(mem_wd), 64'd0);
    check({tag, "_p0_rvalid"}, 64'(p0_rvalid), 64'd0);
    check({tag, "_p1_rvalid"}, 64'(p1_rvalid), 64'd0);
    check({tag, "_p0_rdata"}, 64'(p0_rdata), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ARB_IDLE));
  endtask

  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    cur_w = -1;
    model_reset();

    // Reset with both ports requesting garbage writes under lock.
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b1; we[p] = 1'b1; lock[p] = 1'b1;
      addr[p] = $urandom; wd[p] = $urandom;
    end
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;

    // Port 0 alone: write then read back address 0.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = '0; wd[0] = 32'hAAAABBBB;
    cycle();
    we[0] = 1'b0;
    cycle();
    req[0] = 1'b0;
    cycle();
    check("p0_readback", 64'(p0_rdata), 64'h0000_0000_AAAA_BBBB);

    // Both ports request reads for four cycles.
    req[0] = 1'b1; addr[0] = AW'($urandom_range(0, NW-1));
    req[1] = 1'b1; addr[1] = AW'($urandom_range(0, NW-1));
    for (int k = 0; k < 4; k++) cycle();
    clear_inputs();
    cycle();

    // Port 1 read-modify-write of address 2 under lock while port 0 keeps asking.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 2; wd[0] = 32'h00001133;
    cycle();
    clear_inputs();
    req[1] = 1'b1; addr[1] = 2; lock[1] = 1'b1;
    cycle();
    req[0] = 1'b1; addr[0] = AW'($urandom_range(0, NW-1));
    we[1] = 1'b1; wd[1] = exp_rdata[1] + 1; lock[1] = 1'b0;
    cycle();
    req[1] = 1'b0; we[1] = 1'b0;
    cycle();
    check("rmw_mem2", 64'(mem[2]), 64'h0000_0000_0000_1134);
    clear_inputs();
    cycle();

    // Idle with garbage on every request-side input.
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 2; p++) begin
        req[p] = 1'b0; we[p] = 1'($urandom_range(0, 1)); lock[p] = 1'($urandom_range(0, 1));
        addr[p] = $urandom; wd[p] = $urandom;
      end
      cycle();
    end

    // Random traffic; a pending request and its fields are held until granted.
    clear_inputs();
    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(req[p] && cur_w != p)) begin
          req[p]  = 1'($urandom_range(0, 1));
          we[p]   = 1'($urandom_range(0, 1));
          addr[p] = AW'($urandom_range(0, NW-1));
          wd[p]   = $urandom;
          lock[p] = ($urandom_range(0, 3) == 0);
        end
      end
      cycle();
    end
    clear_inputs();
    cycle();
    cycle();

    // Reset while port 0 holds the lock with a read just granted.
    req[0] = 1'b1; addr[0] = 5; lock[0] = 1'b1;
    cycle();
    check("lock0_entered", 64'(dbg_state), 64'(ARB_LOCK0));
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk); #1;
    clear_inputs();
    req[1] = 1'b1; addr[1] = 7;
    rst_n = 1'b1;
    cycle();
    clear_inputs();
    cycle();

    for (int i = 0; i < NW; i++) check($sformatf("mem[%0d]", i), 64'(mem[i]), 64'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
